cntry_vehicle_detect: RTL and testbench

- Upstream stage of the highway/country signal controller; generates its country-road request input X.
- Synchronises and debounces the raw country-road loop sensor and counts vehicles waiting on the country road.
- Holds X while vehicles remain, and uses the controller's cntry colour to retire vehicles as they depart.
- Clears the request on departure of the last vehicle or on a gap-out.

---
 rtl/cntry_vehicle_detect_pkg.sv | 21 ++
 rtl/sensor_debounce.sv | 59 +++++
 rtl/cntry_vehicle_detect.sv | 134 +++++++++++++
 tb/tb_cntry_vehicle_detect.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cntry_vehicle_detect_pkg.sv
// Shared constants for the country-road detector and the signal controller.
//   - Country light colour codes (2-bit): RED, YELLOW, GREEN. Code 3 is illegal
//     and is treated by consumers as "not GREEN".
//   - Detector state encoding (2-bit): ST_IDLE, ST_REQUEST, ST_SERVE.
//   - Default debounce length and gap-out length.
package cntry_vehicle_detect_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVE   = 2'd2
    } det_state_e;

    localparam int DEFAULT_DEBOUNCE   = 4;
    localparam int DEFAULT_GAP_CYCLES = 8;

endpackage

// File: rtl/sensor_debounce.sv
// Synchroniser and debounce filter for the raw country-road loop sensor.
// Ports:
//   clock      in   system clock (posedge)
//   clear_n    in   synchronous active-low reset
//   sensor_raw in   asynchronous loop detector, 1 = vehicle over loop
//   filt       out  debounced sensor level (registered)
//   rise       out  high in the cycle whose closing edge toggles filt 0->1
//   fall       out  high in the cycle whose closing edge toggles filt 1->0
// rise/fall are combinational look-ahead strobes so the consumer can update
// its own registers on the very edge where filt toggles.
module sensor_debounce
    import cntry_vehicle_detect_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic clock,
    input  logic clear_n,
    input  logic sensor_raw,
    output logic filt,
    output logic rise,
    output logic fall
);

    // Counter only needs to reach DEBOUNCE-1; the edge that would make it
    // DEBOUNCE toggles filt instead.
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic            s1;
    logic            s2;
    logic [DB_W-1:0] db_cnt;
    logic            differs;
    logic            accept;

    assign differs = (s2 != filt);
    assign accept  = differs && (db_cnt == DB_W'(DEBOUNCE - 1));
    assign rise    = accept && !filt;
    assign fall    = accept && filt;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
            if (accept) begin
                filt   <= ~filt;
                db_cnt <= '0;
            end else if (differs) begin
                db_cnt <= db_cnt + DB_W'(1);
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cntry_vehicle_detect.sv
// Country-road vehicle detector: produces the controller's request input X.
// Counts debounced arrivals, retires vehicles on departures while the country
// light is GREEN, and force-clears the count if the loop stays empty for
// GAP_CYCLES cycles during GREEN service.
// Ports:
//   clock      in   system clock (posedge)
//   clear_n    in   synchronous active-low reset
//   sensor_raw in   asynchronous loop detector, 1 = vehicle over loop
//   cntry      in   country light colour (RED/YELLOW/GREEN, 3 = illegal)
//   X          out  registered vehicle-waiting request (REQUEST or SERVE)
//   car_count  out  registered waiting/being-served vehicle count, saturating
//   gap_out    out  registered one-cycle pulse on gap-timer force-clear
//   state      out  current detector state (debug visibility)
module cntry_vehicle_detect
    import cntry_vehicle_detect_pkg::*;
#(
    parameter int DEBOUNCE   = DEFAULT_DEBOUNCE,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int CNT_W      = 3
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sensor_raw,
    input  logic [1:0]       cntry,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             gap_out,
    output logic [1:0]       state
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic             filt;
    logic             rise;
    logic             fall;
    logic             is_green;
    logic             gap_run;
    logic             gap_expire;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] next_count;
    logic             next_x;
    det_state_e       cur_state;
    det_state_e       next_state;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clock      (clock),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .filt       (filt),
        .rise       (rise),
        .fall       (fall)
    );

    // Illegal colour code 3 is simply not GREEN.
    assign is_green  = (cntry == GREEN);
    assign count_inc = (car_count == {CNT_W{1'b1}}) ? car_count : car_count + CNT_W'(1);

    // Gap timer runs only while serving an empty loop; an arrival on the
    // would-be expiry edge suppresses the gap-out.
    assign gap_run    = (cur_state == ST_SERVE) && !filt && !rise;
    assign gap_expire = gap_run && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // State register (plus the registered outputs and gap timer).
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            cur_state <= ST_IDLE;
            car_count <= '0;
            X         <= 1'b0;
            gap_out   <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            cur_state <= next_state;
            car_count <= next_count;
            X         <= next_x;
            gap_out   <= gap_expire;
            gap_cnt   <= (gap_run && !gap_expire) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    // Next-state and next-count.
    always_comb begin
        next_state = cur_state;
        next_count = car_count;
        case (cur_state)
            ST_IDLE: begin
                if (rise) begin
                    next_state = ST_REQUEST;
                    next_count = CNT_W'(1);
                end
            end
            ST_REQUEST: begin
                if (rise) begin
                    next_count = count_inc;
                end
                if (is_green) begin
                    next_state = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (fall && (car_count == CNT_W'(1))) begin
                    next_state = ST_IDLE;
                    next_count = '0;
                end else if (gap_expire) begin
                    next_state = ST_IDLE;
                    next_count = '0;
                end else begin
                    if (rise) begin
                        next_count = count_inc;
                    end else if (fall && (car_count != '0)) begin
                        next_count = car_count - CNT_W'(1);
                    end
                    if (!is_green && (car_count != '0)) begin
                        next_state = ST_REQUEST;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_count = '0;
            end
        endcase
    end

    // Output decode: request is asserted whenever vehicles are tracked.
    always_comb begin
        next_x = (next_state == ST_REQUEST) || (next_state == ST_SERVE);
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cntry_vehicle_detect.sv
// Directed bench for cntry_vehicle_detect. A default instance (CNT_W=3) and a
// CNT_W=2 instance share the same stimulus; outputs are sampled 1 time unit
// after each rising edge, and inputs change at that same point.
module tb_cntry_vehicle_detect;
    import cntry_vehicle_detect_pkg::*;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       sensor_raw;
    logic [1:0] cntry;

    logic       x1;
    logic [2:0] cnt1;
    logic       gap1;
    logic [1:0] st1;
    logic       x2;
    logic [1:0] cnt2;
    logic       gap2;
    logic [1:0] st2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cntry_vehicle_detect dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .cntry      (cntry),
        .X          (x1),
        .car_count  (cnt1),
        .gap_out    (gap1),
        .state      (st1)
    );

    cntry_vehicle_detect #(.CNT_W(2)) dut2 (
        .clock      (clock),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .cntry      (cntry),
        .X          (x2),
        .car_count  (cnt2),
        .gap_out    (gap2),
        .state      (st2)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic ex, input logic [2:0] ec,
                              input logic eg, input logic [1:0] es);
        check({tag, ".X"},         8'(x1),   8'(ex));
        check({tag, ".car_count"}, 8'(cnt1), 8'(ec));
        check({tag, ".gap_out"},   8'(gap1), 8'(eg));
        check({tag, ".state"},     8'(st1),  8'(es));
    endtask

    task automatic check_small(input string tag, input logic ex, input logic [1:0] ec,
                               input logic eg, input logic [1:0] es);
        check({tag, ".X2"},         8'(x2),   8'(ex));
        check({tag, ".car_count2"}, 8'(cnt2), 8'(ec));
        check({tag, ".gap_out2"},   8'(gap2), 8'(eg));
        check({tag, ".state2"},     8'(st2),  8'(es));
    endtask

    initial begin
        // 1: reset with the sensor high, then release; accept on edge 6.
        clear_n    = 1'b0;
        sensor_raw = 1'b1;
        cntry      = RED;
        step(2);
        check_main("t1_reset", 1'b0, 3'd0, 1'b0, ST_IDLE);
        check_small("t1_reset", 1'b0, 2'd0, 1'b0, ST_IDLE);
        clear_n = 1'b1;
        step(5);
        check_main("t1_edge5", 1'b0, 3'd0, 1'b0, ST_IDLE);
        step(1);
        check_main("t1_edge6", 1'b1, 3'd1, 1'b0, ST_REQUEST);

        // 2: a 3-cycle glitch is rejected.
        clear_n    = 1'b0;
        sensor_raw = 1'b0;
        step(1);
        clear_n = 1'b1;
        step(2);
        sensor_raw = 1'b1;
        step(3);
        sensor_raw = 1'b0;
        step(10);
        check_main("t2_glitch", 1'b0, 3'd0, 1'b0, ST_IDLE);

        // 3: held arrival under RED.
        sensor_raw = 1'b1;
        step(5);
        check_main("t3_edge5", 1'b0, 3'd0, 1'b0, ST_IDLE);
        step(1);
        check_main("t3_edge6", 1'b1, 3'd1, 1'b0, ST_REQUEST);
        step(10);
        check_main("t3_hold", 1'b1, 3'd1, 1'b0, ST_REQUEST);

        // 4: falls ignored while requesting; build count to 3 under RED.
        sensor_raw = 1'b0;
        step(8);
        check_main("t4_fall_ignored", 1'b1, 3'd1, 1'b0, ST_REQUEST);
        sensor_raw = 1'b1;
        step(8);
        sensor_raw = 1'b0;
        step(8);
        sensor_raw = 1'b1;
        step(8);
        check_main("t4_three", 1'b1, 3'd3, 1'b0, ST_REQUEST);
        check_small("t4_three", 1'b1, 2'd3, 1'b0, ST_REQUEST);
        cntry = GREEN;
        step(1);
        check_main("t4_serve", 1'b1, 3'd3, 1'b0, ST_SERVE);
        sensor_raw = 1'b0;
        step(5);
        check_main("t4_before_depart", 1'b1, 3'd3, 1'b0, ST_SERVE);
        step(1);
        check_main("t4_depart", 1'b1, 3'd2, 1'b0, ST_SERVE);

        // 5: empty loop for 8 cycles in SERVE forces gap-out.
        step(7);
        check_main("t5_gap_minus1", 1'b1, 3'd2, 1'b0, ST_SERVE);
        step(1);
        check_main("t5_gap", 1'b0, 3'd0, 1'b1, ST_IDLE);
        step(1);
        check_main("t5_gap_pulse_end", 1'b0, 3'd0, 1'b0, ST_IDLE);

        // Last departure in SERVE clears X on the fall edge.
        sensor_raw = 1'b1;
        step(6);
        check_main("t4b_arrive", 1'b1, 3'd1, 1'b0, ST_REQUEST);
        step(1);
        check_main("t4b_serve", 1'b1, 3'd1, 1'b0, ST_SERVE);
        sensor_raw = 1'b0;
        step(5);
        check_main("t4b_before_last", 1'b1, 3'd1, 1'b0, ST_SERVE);
        step(1);
        check_main("t4b_last_fall", 1'b0, 3'd0, 1'b0, ST_IDLE);

        // 5b: an arrival on the gap-expiry edge wins over the gap-out.
        cntry      = RED;
        sensor_raw = 1'b1;
        step(8);
        sensor_raw = 1'b0;
        step(8);
        sensor_raw = 1'b1;
        step(8);
        sensor_raw = 1'b0;
        step(8);
        check_main("t5b_two", 1'b1, 3'd2, 1'b0, ST_REQUEST);
        cntry = GREEN;
        step(1);
        check_main("t5b_serve", 1'b1, 3'd2, 1'b0, ST_SERVE);
        step(2);
        sensor_raw = 1'b1;
        step(5);
        check_main("t5b_gap_minus1", 1'b1, 3'd2, 1'b0, ST_SERVE);
        step(1);
        check_main("t5b_expiry_rise", 1'b1, 3'd3, 1'b0, ST_SERVE);
        step(1);
        check_main("t5b_after", 1'b1, 3'd3, 1'b0, ST_SERVE);

        // 6: leaving GREEN with vehicles returns to REQUEST; illegal colour
        // is not GREEN; saturation; mid-run reset.
        cntry = YELLOW;
        step(1);
        check_main("t6_yellow", 1'b1, 3'd3, 1'b0, ST_REQUEST);
        cntry = 2'd3;
        step(2);
        check_main("t6_illegal", 1'b1, 3'd3, 1'b0, ST_REQUEST);
        cntry      = RED;
        sensor_raw = 1'b0;
        step(8);
        sensor_raw = 1'b1;
        step(8);
        sensor_raw = 1'b0;
        step(8);
        sensor_raw = 1'b1;
        step(8);
        check_main("t6_five", 1'b1, 3'd5, 1'b0, ST_REQUEST);
        check_small("t6_saturate", 1'b1, 2'd3, 1'b0, ST_REQUEST);
        sensor_raw = 1'b0;
        step(3);
        clear_n = 1'b0;
        step(1);
        check_main("t6_reset", 1'b0, 3'd0, 1'b0, ST_IDLE);
        check_small("t6_reset", 1'b0, 2'd0, 1'b0, ST_IDLE);
        clear_n = 1'b1;
        step(10);
        check_main("t6_no_residue", 1'b0, 3'd0, 1'b0, ST_IDLE);
        check_small("t6_no_residue", 1'b0, 2'd0, 1'b0, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
